pndes: RTL

//  Receive-side deserializer for the pseudo-random serial link. Hunts the 1-bit

---
 rtl/pndes_if.sv | 25 ++
 rtl/pndes.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pndes_if.sv
// Receive-side link bundle: serial line in, payload word out with valid/ready.
// The master side belongs to the deserializer, the slave side to the line
// driver plus the downstream checker.
interface pndes_if #(
    parameter int LW = 5,
    parameter int DW = 32
);
    logic          dat_i;
    logic [DW-1:0] dat_o;
    logic [LW-1:0] len_o;
    logic          vld_o;
    logic          rdy_i;
    logic          err_o;
    logic          ovf_o;

    modport master (
        input  dat_i, rdy_i,
        output dat_o, len_o, vld_o, err_o, ovf_o
    );

    modport slave (
        output dat_i, rdy_i,
        input  dat_o, len_o, vld_o, err_o, ovf_o
    );
endinterface

// File: rtl/pndes.sv
// Serial frame deserializer: hunts for the header, captures LEN and LEN+1
// payload bits (bit0 first), verifies the footer and hands the word to the
// consumer through a valid/ready register stage.
module pndes #(
    parameter int            HW  = 8,
    parameter logic [HW-1:0] HDR = 8'hA5,
    parameter logic [HW-1:0] FTR = 8'h5A,
    parameter int            LW  = 5,
    parameter int            DW  = 32
) (
    input  logic     clk_i,
    input  logic     rst_i,
    pndes_if.master  bus
);
    // One counter serves LEN, DATA and FOOT, so it must span the widest phase.
    localparam int CW = (LW > $clog2(HW)) ? LW : $clog2(HW);

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_LEN  = 2'd1,
        S_DATA = 2'd2,
        S_FOOT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] shadow_q, shadow_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [LW-1:0] len_o_q, len_o_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;

    // Sliding window including the bit on the line this cycle.
    logic [HW-1:0] win;
    assign win = {sr_q[HW-2:0], bus.dat_i};

    // Next-state and output computation for the frame walker and handshake.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        shadow_d = shadow_q;
        dat_d    = dat_q;
        len_o_d  = len_o_q;
        vld_d    = vld_q;
        err_d    = 1'b0;
        ovf_d    = 1'b0;

        // Consumer takes the word; a completing good frame below may re-arm vld.
        if (vld_q && bus.rdy_i) begin
            vld_d = 1'b0;
        end

        case (state_q)
            S_HUNT: begin
                sr_d = win;
                if (win == HDR) begin
                    state_d = S_LEN;
                    cnt_d   = '0;
                end
            end
            S_LEN: begin
                len_d = {len_q[LW-2:0], bus.dat_i};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(LW - 1)) begin
                    state_d  = S_DATA;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            S_DATA: begin
                shadow_d[cnt_q[LW-1:0]] = bus.dat_i;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(len_q)) begin
                    state_d = S_FOOT;
                    cnt_d   = '0;
                end
            end
            S_FOOT: begin
                sr_d  = win;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(HW - 1)) begin
                    state_d = S_HUNT;
                    cnt_d   = '0;
                    // A fresh header must arrive in full after every frame.
                    sr_d    = '0;
                    if (win == FTR) begin
                        dat_d   = shadow_q;
                        len_o_d = len_q;
                        vld_d   = 1'b1;
                        ovf_d   = vld_q && !bus.rdy_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_HUNT;
            sr_q     <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            shadow_q <= '0;
            dat_q    <= '0;
            len_o_q  <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            shadow_q <= shadow_d;
            dat_q    <= dat_d;
            len_o_q  <= len_o_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.dat_o = dat_q;
    assign bus.len_o = len_o_q;
    assign bus.vld_o = vld_q;
    assign bus.err_o = err_q;
    assign bus.ovf_o = ovf_q;
endmodule
